// File: rtl/pipe_register.sv
// Elastic valid/ready register pipeline of DEPTH stages. Bubbles collapse
// through a combinational ready chain, so a ready consumer sees one word per cycle.
module pipe_register #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count
);

    logic [DEPTH-1:0] v_r;
    logic [WIDTH-1:0] d_r    [DEPTH];
    logic [CNT_W-1:0] count_r;

    logic [DEPTH:0]   r_s;
    logic [DEPTH-1:0] up_v_s;
    logic [WIDTH-1:0] up_d_s [DEPTH];
    logic             in_xfer_s;
    logic             out_xfer_s;

    // Occupancy update; at most one push and one pop per edge, so no overflow.
    function automatic logic [CNT_W-1:0] count_next(
        input logic [CNT_W-1:0] cur,
        input logic             push,
        input logic             pop
    );
        logic [CNT_W-1:0] push_w;
        logic [CNT_W-1:0] pop_w;
        push_w = {{(CNT_W-1){1'b0}}, push};
        pop_w  = {{(CNT_W-1){1'b0}}, pop};
        return cur + push_w - pop_w;
    endfunction

    // Ready chain from the consumer back to the producer.
    always_comb begin
        r_s        = '0;
        r_s[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            r_s[i] = ~v_r[i] | r_s[i+1];
        end
    end

    // Upstream view of each stage: stage 0 sees the producer, others the previous stage.
    always_comb begin
        up_v_s    = '0;
        up_v_s[0] = in_valid;
        up_d_s[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            up_v_s[i] = v_r[i-1];
            up_d_s[i] = d_r[i-1];
        end
    end

    // Handshake qualifiers; flush blocks the producer but not the consumer.
    always_comb begin
        in_ready   = r_s[0] & ~flush;
        in_xfer_s  = in_valid & in_ready;
        out_xfer_s = v_r[DEPTH-1] & out_ready;
    end

    // Stage valid bits: cleared by reset or flush, otherwise advance when ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_r <= '0;
        end else if (flush) begin
            v_r <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_s[i]) begin
                    v_r[i] <= up_v_s[i];
                end else begin
                    v_r[i] <= v_r[i];
                end
            end
        end
    end

    // Stage data: only loaded when a valid word moves in; flush leaves data untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                d_r[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                d_r[i] <= d_r[i];
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_s[i] && up_v_s[i]) begin
                    d_r[i] <= up_d_s[i];
                end else begin
                    d_r[i] <= d_r[i];
                end
            end
        end
    end

    // Live occupancy count; a pop during flush is still consumed, count simply restarts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (flush) begin
            count_r <= '0;
        end else begin
            count_r <= count_next(count_r, in_xfer_s, out_xfer_s);
        end
    end

    // Output side is driven straight from the last stage registers.
    always_comb begin
        out_valid = v_r[DEPTH-1];
        out_data  = d_r[DEPTH-1];
        count     = count_r;
    end

endmodule

// File: tb/tb_pipe_register.sv
// Directed self-checking bench for pipe_register with WIDTH=8, DEPTH=3.
module tb_pipe_register;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] count;

    int pass_cnt;
    int total_cnt;

    pipe_register #(.WIDTH(8), .DEPTH(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        step();
        rst = 1'b0;
        in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b1;
        step(); step(); step();
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C) $display("FAIL reset_pre_traffic got v=%b d=%h exp v=1 d=3c", out_valid, out_data);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || count !== 2'd0) $display("FAIL reset_async got v=%b d=%h c=%0d exp v=0 d=00 c=0", out_valid, out_data, count);
        else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 2'd0) $display("FAIL reset_release got rdy=%b v=%b c=%0d exp rdy=1 v=0 c=0", in_ready, out_valid, count);
        else pass_cnt++;
    endtask

    task automatic test_latency();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
        step();
        in_valid = 1'b0; in_data = 8'h00;
        total_cnt++;
        if (out_valid !== 1'b0 || count !== 2'd1) $display("FAIL latency_edge0 got v=%b c=%0d exp v=0 c=1", out_valid, count);
        else pass_cnt++;
        step();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL latency_edge1 got v=%b exp v=0", out_valid);
        else pass_cnt++;
        step();
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5) $display("FAIL latency_edge2 got v=%b d=%h exp v=1 d=a5", out_valid, out_data);
        else pass_cnt++;
        step();
        total_cnt++;
        if (out_valid !== 1'b0 || count !== 2'd0) $display("FAIL latency_after got v=%b c=%0d exp v=0 c=0", out_valid, count);
        else pass_cnt++;
    endtask

    task automatic test_streaming();
        logic [7:0] exp_d;
        out_ready = 1'b1;
        for (int k = 0; k < 18; k++) begin
            in_valid = (k < 16);
            in_data  = 8'(k + 1);
            step();
            if (k >= 2) begin
                exp_d = 8'(k - 1);
                total_cnt++;
                if (out_valid !== 1'b1 || out_data !== exp_d) $display("FAIL stream_out k=%0d got v=%b d=%h exp v=1 d=%h", k, out_valid, out_data, exp_d);
                else pass_cnt++;
            end
            if (k >= 2 && k <= 15) begin
                total_cnt++;
                if (count !== 2'd3) $display("FAIL stream_count k=%0d got %0d exp 3", k, count);
                else pass_cnt++;
            end
        end
        in_valid = 1'b0;
        step();
        total_cnt++;
        if (out_valid !== 1'b0 || count !== 2'd0) $display("FAIL stream_drained got v=%b c=%0d exp v=0 c=0", out_valid, count);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'h11; step();
        in_data = 8'h22; step();
        in_data = 8'h33; step();
        in_data = 8'h44; #1;
        total_cnt++;
        if (in_ready !== 1'b0 || count !== 2'd3 || out_data !== 8'h11) $display("FAIL bp_full got rdy=%b c=%0d d=%h exp rdy=0 c=3 d=11", in_ready, count, out_data);
        else pass_cnt++;
        step();
        total_cnt++;
        if (in_ready !== 1'b0 || count !== 2'd3 || out_valid !== 1'b1 || out_data !== 8'h11) $display("FAIL bp_hold got rdy=%b c=%0d v=%b d=%h exp rdy=0 c=3 v=1 d=11", in_ready, count, out_valid, out_data);
        else pass_cnt++;
        out_ready = 1'b1; #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL bp_pop_push_ready got %b exp 1", in_ready);
        else pass_cnt++;
        step();
        in_valid = 1'b0;
        total_cnt++;
        if (count !== 2'd3 || out_data !== 8'h22) $display("FAIL bp_pop_push got c=%0d d=%h exp c=3 d=22", count, out_data);
        else pass_cnt++;
        step();
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== 8'h33) $display("FAIL bp_drain1 got v=%b d=%h exp v=1 d=33", out_valid, out_data);
        else pass_cnt++;
        step();
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== 8'h44) $display("FAIL bp_drain2 got v=%b d=%h exp v=1 d=44", out_valid, out_data);
        else pass_cnt++;
        step();
        total_cnt++;
        if (out_valid !== 1'b0 || count !== 2'd0) $display("FAIL bp_empty got v=%b c=%0d exp v=0 c=0", out_valid, count);
        else pass_cnt++;
    endtask

    task automatic test_bubble();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h0A; step();
        in_valid = 1'b0; step();
        in_valid = 1'b1; in_data = 8'h0B; step();
        in_valid = 1'b0; step();
        total_cnt++;
        if (count !== 2'd2 || in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'h0A) $display("FAIL bubble_pack got c=%0d rdy=%b v=%b d=%h exp c=2 rdy=1 v=1 d=0a", count, in_ready, out_valid, out_data);
        else pass_cnt++;
        out_ready = 1'b1;
        step();
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== 8'h0B) $display("FAIL bubble_next got v=%b d=%h exp v=1 d=0b", out_valid, out_data);
        else pass_cnt++;
        step();
        total_cnt++;
        if (out_valid !== 1'b0 || count !== 2'd0) $display("FAIL bubble_empty got v=%b c=%0d exp v=0 c=0", out_valid, count);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'h55; step();
        in_data = 8'h66; step();
        in_data = 8'h77; step();
        in_data = 8'h99; flush = 1'b1; #1;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL flush_ready got %b exp 0", in_ready);
        else pass_cnt++;
        step();
        flush = 1'b0; in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0 || count !== 2'd0 || out_data !== 8'h55) $display("FAIL flush_clear got v=%b c=%0d d=%h exp v=0 c=0 d=55", out_valid, count, out_data);
        else pass_cnt++;
        in_valid = 1'b1; in_data = 8'h88; step();
        in_valid = 1'b0; step();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL flush_push_early got v=%b exp 0", out_valid);
        else pass_cnt++;
        step();
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== 8'h88 || count !== 2'd1) $display("FAIL flush_push got v=%b d=%h c=%0d exp v=1 d=88 c=1", out_valid, out_data, count);
        else pass_cnt++;
        // Consumer takes 0x88 in the same cycle as a flush; it must not come back.
        out_ready = 1'b1; flush = 1'b1; step();
        flush = 1'b0; step();
        total_cnt++;
        if (out_valid !== 1'b0 || count !== 2'd0) $display("FAIL flush_pop got v=%b c=%0d exp v=0 c=0", out_valid, count);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_latency();
        test_streaming();
        test_backpressure();
        test_bubble();
        test_flush();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
